// File: rtl/mux_stream_arb.sv
// Registered N-channel stream multiplexer with valid/ready on every port.
// Fixed-select or round-robin grant feeds a single output register.
module mux_stream_arb #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rr_mode,
    input  logic [SEL_W-1:0]         select_lines,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int unsigned DBL_W = 2 * NUM_CH;

    logic              run_q;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic              out_valid_q, out_valid_d;

    logic              load_en;
    logic [DBL_W-1:0]  rr_dbl;
    logic [NUM_CH-1:0] rr_rot;
    logic              rr_ok;
    int unsigned       rr_off;
    int unsigned       rr_idx;
    logic [SEL_W-1:0]  rr_gnt;
    logic              fix_ok;
    logic [SEL_W-1:0]  grant;
    logic              gnt_ok;
    logic              xfer;
    logic [DATA_W-1:0] gnt_data;

    assign load_en = !out_valid_q || out_ready;

    // Rotate valids so bit 0 is the channel right after the last one served.
    assign rr_dbl = {in_valid, in_valid} >> (32'(ptr_q) + 32'd1);
    assign rr_rot = rr_dbl[NUM_CH-1:0];

    always_comb begin
        rr_ok  = 1'b0;
        rr_off = 0;
        for (int unsigned j = 0; j < NUM_CH; j++) begin
            if (!rr_ok && rr_rot[j]) begin
                rr_ok  = 1'b1;
                rr_off = j;
            end
        end
        rr_idx = 32'(ptr_q) + 32'd1 + rr_off;
        if (rr_idx >= NUM_CH) begin
            rr_idx = rr_idx - NUM_CH;
        end
        rr_gnt = SEL_W'(rr_idx);
    end

    // Out-of-range selects match no channel and therefore never grant.
    always_comb begin
        fix_ok = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (select_lines == SEL_W'(i)) begin
                fix_ok = in_valid[i];
            end
        end
    end

    assign grant  = rr_mode ? rr_gnt : select_lines;
    assign gnt_ok = rr_mode ? rr_ok : fix_ok;
    // run_q holds off grants until the first edge after reset release.
    assign xfer   = run_q && load_en && gnt_ok;

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                in_ready[i] = xfer;
                gnt_data    = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = gnt_data;
            out_ch_d    = grant;
            out_valid_d = 1'b1;
            ptr_d       = grant;
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            ptr_q       <= SEL_W'(NUM_CH - 1);
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_stream_arb.sv
// Scoreboard bench for mux_stream_arb: directed phases push expected words,
// a negedge monitor pops and compares every word the consumer accepts.
module tb_mux_stream_arb;

    localparam int unsigned NCH  = 8;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = 3;
    localparam int unsigned NCH2 = 6;

    logic            clk;
    logic            rst_n;
    logic            rr_mode;
    logic [SW-1:0]   select_lines;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]  in_valid;
    logic [NCH-1:0]  in_ready;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_ch;
    logic            out_valid;
    logic            out_ready;

    logic            rr_mode2;
    logic [SW-1:0]   select_lines2;
    logic [NCH2*DW-1:0] in_data2;
    logic [NCH2-1:0] in_valid2;
    logic [NCH2-1:0] in_ready2;
    logic [DW-1:0]   out_data2;
    logic [SW-1:0]   out_ch2;
    logic            out_valid2;
    logic            out_ready2;

    logic [DW-1:0]   dat [NCH];
    logic [SW+DW-1:0] exp_q [$];
    int checks;
    int errors;

    mux_stream_arb #(.NUM_CH(NCH), .DATA_W(DW), .SEL_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode), .select_lines(select_lines),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_stream_arb #(.NUM_CH(NCH2), .DATA_W(DW), .SEL_W(SW)) dut6 (
        .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode2), .select_lines(select_lines2),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_ch(out_ch2), .out_valid(out_valid2), .out_ready(out_ready2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) in_data[i*DW +: DW] = dat[i];
        for (int i = 0; i < NCH2; i++) in_data2[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch);
        exp_q.push_back({SW'(ch), dat[ch]});
    endtask

    task automatic drain();
        in_valid  = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor: a word shown with out_ready=1 at negedge is consumed at the next edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual ch=%0d data=%h expected none", out_ch, out_data);
            end else begin
                check("out_word", 64'({out_ch, out_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < NCH; i++) dat[i] = 32'h5555_0000 + 32'(i);
        rst_n = 1'b1; rr_mode = 1'b0; select_lines = '0;
        in_valid = 8'hFF; out_ready = 1'b1;
        rr_mode2 = 1'b0; select_lines2 = '0; in_valid2 = 6'h3F; out_ready2 = 1'b1;
        #2 rst_n = 1'b0;

        // Reset state, with every channel valid
        #10;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_ch", 64'(out_ch), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        select_lines = 3'd5;
        check("rel_in_ready", 64'(in_ready), 64'd0);
        tick();

        // Fixed select, ch5, one transfer per clock
        check("fix_in_ready", 64'(in_ready), 64'h20);
        for (int k = 0; k < 4; k++) push(5);
        repeat (4) tick();
        drain();

        // Out-of-range select on the 6-channel instance
        check("oor_hold_valid", 64'(out_valid2), 64'd1);
        select_lines2 = 3'd7;
        #1;
        check("oor_in_ready", 64'(in_ready2), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("oor_in_ready", 64'(in_ready2), 64'd0);
            check("oor_out_valid", 64'(out_valid2), 64'd0);
        end

        // Round-robin from reset pointer: 0,2,5,7,0,2,5,7
        do_reset();
        rr_mode = 1'b1;
        in_valid = 8'b1010_0101;
        push(0); push(2); push(5); push(7); push(0); push(2); push(5); push(7);
        repeat (8) tick();
        drain();

        // Backpressure on a ch3 word, then refill with no bubble
        rr_mode = 1'b0;
        select_lines = 3'd3;
        dat[3] = 32'hDEAD_BEEF;
        in_valid = 8'hFF;
        out_ready = 1'b0;
        push(3);
        tick();
        select_lines = 3'd5;
        for (int k = 0; k < 4; k++) begin
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_ch", 64'(out_ch), 64'd3);
            check("bp_out_data", 64'(out_data), 64'hDEAD_BEEF);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'h20);
        push(5);
        tick();
        check("bp_no_bubble_ch", 64'(out_ch), 64'd5);
        drain();
        dat[3] = 32'h5555_0003;

        // Sparse wrap: serve ch6, then ch1 wins over ch6
        select_lines = 3'd6;
        in_valid = 8'h40;
        push(6);
        tick();
        rr_mode = 1'b1;
        in_valid = 8'h42;
        push(1); push(6); push(1); push(6);
        repeat (4) tick();
        drain();

        // Async reset mid-stream discards the held word
        in_valid = 8'hFF;
        push(7);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("arst_rel_ready", 64'(in_ready), 64'd0);
        tick();
        check("arst_first_ready", 64'(in_ready), 64'h01);
        push(0); push(1); push(2);
        repeat (3) tick();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_stream_arb.md
Name: mux_stream_arb

Overview:
- Parametrised successor to the fixed 8:1 single-bit selector.
- Registered N-channel, W-bit stream multiplexer with valid/ready handshakes on every input and on the output.
- Two run-time modes: fixed select (select_lines chooses the channel) and round-robin arbitration across all requesting channels.
- Sits between multiple producers (fetch, load/store, DMA-style ports) and one shared consumer in the MIPS datapath.

Parameters:
- NUM_CH, 8, number of input channels (2..32).
- DATA_W, 32, data width per channel.
- SEL_W, 3, width of the select and channel-ID fields; must satisfy 2^SEL_W >= NUM_CH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rr_mode  in  1  0 = fixed select, 1 = round-robin.
- select_lines  in  SEL_W  channel chosen when rr_mode=0.
- in_data  in  NUM_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready (one-hot or zero).
- out_data  out  DATA_W  registered output data.
- out_ch  out  SEL_W  channel ID of the word in out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_data=0, out_ch=0.
  - RR pointer ptr=NUM_CH-1, so the first round-robin search starts at channel 0.
  - in_ready=0 while reset is asserted.
- Load enable: load_en = !out_valid || out_ready. The single output stage can accept a new word every cycle; full throughput is 1 word/clk.
- Grant (combinational):
  - rr_mode=0: grant=select_lines, gnt_ok = (select_lines < NUM_CH) && in_valid[select_lines]. Out-of-range select never grants.
  - rr_mode=1: search channels ptr+1, ptr+2, ... with wrap modulo NUM_CH; ptr itself is checked last. grant = first channel with in_valid=1; gnt_ok = |in_valid.
- in_ready[i] = load_en && gnt_ok && (grant==i). At most one bit is set. in_ready must not depend on in_valid of other channels in fixed mode.
- Transfer: handshake on channel i when in_valid[i] && in_ready[i]. At the next edge:
  - out_data <= channel i data, out_ch <= i, out_valid <= 1.
  - ptr <= i. ptr updates in both modes, so the round-robin history tracks the last served channel.
- Load enable with no grant: out_valid <= 0; out_data and out_ch hold their values.
- out_valid=1 and out_ready=0: out_data, out_ch and out_valid hold; all in_ready=0 (backpressure).
- Latency: input handshake at edge k puts the word on out_data, with out_valid=1, after edge k.
- Simultaneous drain and refill (out_ready=1, out_valid=1, gnt_ok=1): the new word replaces the old one in the same edge with no bubble.
- Mode or select change: takes effect on the next grant evaluation (combinational). The word already in the output register is unaffected.
- Fairness (rr_mode=1): with all NUM_CH channels continuously valid and out_ready=1, each channel is served exactly once per NUM_CH consecutive transfers.
- Reset mid-operation: the held word is discarded (out_valid->0 immediately) and ptr returns to NUM_CH-1. No in_ready is asserted until the first edge after rst_n deasserts.
- Producer contract: in_data must be held stable while in_valid=1 and in_ready=0. The block does not check this.

Test Plan:
- Fixed mode: rr_mode=0, select_lines=5, in_valid=8'hFF, ch5 data=32'h5555_0005, out_ready=1 -> in_ready=8'h20; next cycle out_data=32'h5555_0005, out_ch=5, out_valid=1; one transfer per clock.
- Out-of-range select: NUM_CH=6, SEL_W=3, select_lines=7, all valid -> in_ready=0 throughout, out_valid falls to 0 after the first edge and stays 0.
- Round-robin: rr_mode=1, in_valid=8'b1010_0101 held, out_ready=1 -> out_ch sequence 0,2,5,7,0,2,... with no idle cycles.
- Backpressure: word from ch3 (32'hDEAD_BEEF) in register, out_ready=0 for 4 cycles -> out_data and out_ch=3 stable, in_ready=0; out_ready=1 -> next grant taken the same cycle with no bubble.
- Sparse RR wrap: ptr=6 (last served ch6), only ch1 and ch6 valid -> ch1 granted before ch6.
- Async reset mid-stream: rst_n low between clock edges while out_valid=1 -> out_valid=0 immediately; after release with all channels valid in rr_mode=1, the first out_ch=0.
